// File: rtl/game_if.sv
// Bundle of the controller's frame/button inputs and the object state it
// publishes to the renderer. The controller takes the slave side.
interface game_if;
    logic       frame_tick;
    logic       btn_fire;
    logic       btn_continue;
    logic [9:0] player_h;
    logic [9:0] player_v;

    logic       game_start;
    logic       game_playing;
    logic       game_lose;
    logic       game_win;
    logic [9:0] enemy_h;
    logic [9:0] enemy_v;
    logic       enemy1_hit;
    logic       enemy2_hit;
    logic       enemy3_hit;
    logic [9:0] projectile_h;
    logic [9:0] projectile_v;
    logic       projectile_idle;

    modport master (
        output frame_tick, btn_fire, btn_continue, player_h, player_v,
        input  game_start, game_playing, game_lose, game_win,
        input  enemy_h, enemy_v, enemy1_hit, enemy2_hit, enemy3_hit,
        input  projectile_h, projectile_v, projectile_idle
    );

    modport slave (
        input  frame_tick, btn_fire, btn_continue, player_h, player_v,
        output game_start, game_playing, game_lose, game_win,
        output enemy_h, enemy_v, enemy1_hit, enemy2_hit, enemy3_hit,
        output projectile_h, projectile_v, projectile_idle
    );
endinterface

// File: rtl/game_controller.sv
// Game sequencer: owns the game state, the three-enemy formation, the
// player projectile and the hit flags. Motion advances once per frame_tick.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_START   | waiting for btn_continue before the first game
// ST_PLAYING | formation and projectile move on frame_tick, fire accepted
// ST_LOSE    | formation reached the player row; wait for btn_continue
// ST_WIN     | all three enemies destroyed; wait for btn_continue
module game_controller #(
    parameter int H_MIN      = 144,
    parameter int H_MAX      = 783,
    parameter int V_MIN      = 35,
    parameter int ENEMY_STEP = 2,
    parameter int ENEMY_DROP = 20,
    parameter int PROJ_SPEED = 6
) (
    input  logic  clk,
    input  logic  reset,
    game_if.slave bus
);

    // One-hot encoding so each state flag is a register bit.
    typedef enum logic [3:0] {
        ST_START   = 4'b0001,
        ST_PLAYING = 4'b0010,
        ST_LOSE    = 4'b0100,
        ST_WIN     = 4'b1000
    } state_t;

    localparam logic [9:0]  H_MIN_10  = 10'(H_MIN);
    localparam logic [9:0]  V_MIN_10  = 10'(V_MIN);
    localparam logic [9:0]  STEP_10   = 10'(ENEMY_STEP);
    localparam logic [9:0]  DROP_10   = 10'(ENEMY_DROP);
    localparam logic [9:0]  SPEED_10  = 10'(PROJ_SPEED);
    localparam logic [10:0] H_MIN_11  = 11'(H_MIN);
    localparam logic [10:0] H_MAX_11  = 11'(H_MAX);
    localparam logic [10:0] STEP_11   = 11'(ENEMY_STEP);
    localparam logic [10:0] SPEED_11  = 11'(PROJ_SPEED);
    localparam logic [10:0] ENEMY_W   = 11'd75;
    localparam logic [10:0] ENEMY_GAP = 11'd150;
    localparam logic [10:0] FORM_W    = 11'd375;
    localparam logic [10:0] PROJ_W    = 11'd10;
    localparam logic [9:0]  PROJ_XOFF = 10'd32;
    localparam logic [9:0]  PROJ_YOFF = 10'd10;

    state_t     state_q, state_d;
    logic [9:0] eh_q, eh_d;
    logic [9:0] ev_q, ev_d;
    logic       dir_right_q, dir_right_d;
    logic [2:0] hit_q, hit_d;
    logic [9:0] ph_q, ph_d;
    logic [9:0] pv_q, pv_d;
    logic       idle_q, idle_d;

    logic [2:0] overlap;
    logic [2:0] hit_sel;

    // State and object registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_START;
            eh_q        <= H_MIN_10;
            ev_q        <= V_MIN_10;
            dir_right_q <= 1'b1;
            hit_q       <= 3'b000;
            ph_q        <= 10'd0;
            pv_q        <= 10'd0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            eh_q        <= eh_d;
            ev_q        <= ev_d;
            dir_right_q <= dir_right_d;
            hit_q       <= hit_d;
            ph_q        <= ph_d;
            pv_q        <= pv_d;
            idle_q      <= idle_d;
        end
    end

    // Rectangle overlap of the projectile against each enemy, lowest index wins.
    always_comb begin
        logic [10:0] e_left;
        logic        v_ovl;
        overlap = 3'b000;
        v_ovl   = ({1'b0, pv_q} < {1'b0, ev_q} + ENEMY_W) &&
                  ({1'b0, pv_q} + PROJ_W > {1'b0, ev_q});
        for (int k = 0; k < 3; k++) begin
            e_left     = {1'b0, eh_q} + ENEMY_GAP * 11'(k);
            overlap[k] = v_ovl &&
                         ({1'b0, ph_q} < e_left + ENEMY_W) &&
                         ({1'b0, ph_q} + PROJ_W > e_left);
        end
        overlap    = overlap & ~hit_q & {3{~idle_q}};
        hit_sel[0] = overlap[0];
        hit_sel[1] = overlap[1] & ~overlap[0];
        hit_sel[2] = overlap[2] & ~overlap[1] & ~overlap[0];
    end

    // Next-state and next-object values for the current cycle.
    always_comb begin
        state_d     = state_q;
        eh_d        = eh_q;
        ev_d        = ev_q;
        dir_right_d = dir_right_q;
        hit_d       = hit_q;
        ph_d        = ph_q;
        pv_d        = pv_q;
        idle_d      = idle_q;

        case (state_q)
            ST_START, ST_LOSE, ST_WIN: begin
                if (bus.btn_continue) begin
                    state_d     = ST_PLAYING;
                    eh_d        = H_MIN_10;
                    ev_d        = V_MIN_10;
                    dir_right_d = 1'b1;
                    hit_d       = 3'b000;
                    ph_d        = 10'd0;
                    pv_d        = 10'd0;
                    idle_d      = 1'b1;
                end
            end

            ST_PLAYING: begin
                // A launch takes precedence over moving, so a new shot
                // never advances on the frame it is fired.
                if (bus.btn_fire && idle_q) begin
                    idle_d = 1'b0;
                    ph_d   = bus.player_h + PROJ_XOFF;
                    pv_d   = bus.player_v - PROJ_YOFF;
                end else if (bus.frame_tick && !idle_q) begin
                    if (|hit_sel) begin
                        hit_d  = hit_q | hit_sel;
                        idle_d = 1'b1;
                        ph_d   = 10'd0;
                        pv_d   = 10'd0;
                    end else if ({1'b0, pv_q} < SPEED_11) begin
                        idle_d = 1'b1;
                        ph_d   = 10'd0;
                        pv_d   = 10'd0;
                    end else begin
                        pv_d = pv_q - SPEED_10;
                    end
                end

                if (bus.frame_tick) begin
                    if (dir_right_q) begin
                        if ({1'b0, eh_q} + FORM_W + STEP_11 > H_MAX_11 + 11'd1) begin
                            dir_right_d = 1'b0;
                            ev_d        = ev_q + DROP_10;
                        end else begin
                            eh_d = eh_q + STEP_10;
                        end
                    end else begin
                        if ({1'b0, eh_q} < H_MIN_11 + STEP_11) begin
                            dir_right_d = 1'b1;
                            ev_d        = ev_q + DROP_10;
                        end else begin
                            eh_d = eh_q - STEP_10;
                        end
                    end

                    if (&hit_d) begin
                        state_d = ST_WIN;
                    end else if ({1'b0, ev_q} + ENEMY_W >= {1'b0, bus.player_v}) begin
                        state_d = ST_LOSE;
                    end
                end
            end

            default: state_d = ST_START;
        endcase
    end

    assign bus.game_start      = state_q[0];
    assign bus.game_playing    = state_q[1];
    assign bus.game_lose       = state_q[2];
    assign bus.game_win        = state_q[3];
    assign bus.enemy_h         = eh_q;
    assign bus.enemy_v         = ev_q;
    assign bus.enemy1_hit      = hit_q[0];
    assign bus.enemy2_hit      = hit_q[1];
    assign bus.enemy3_hit      = hit_q[2];
    assign bus.projectile_h    = ph_q;
    assign bus.projectile_v    = pv_q;
    assign bus.projectile_idle = idle_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed vector bench for game_controller. Each record holds one set of
// inputs, how many cycles to hold them, and the outputs expected afterwards.
module tb_game_controller;

    logic clk;
    logic reset;

    game_if bus();

    game_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_START = 4'b0001;
    localparam logic [3:0] S_PLAY  = 4'b0010;
    localparam logic [3:0] S_LOSE  = 4'b0100;
    localparam logic [3:0] S_WIN   = 4'b1000;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       fire;
        logic       cont;
        logic [9:0] pl_h;
        logic [9:0] pl_v;
        int         reps;
        logic [3:0] st;
        logic [9:0] eh;
        logic [9:0] ev;
        logic [2:0] hits;
        logic       idle;
        logic [9:0] prh;
        logic [9:0] prv;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic tick, input logic fire,
                                input logic cont, input logic [9:0] pl_h,
                                input logic [9:0] pl_v, input int reps,
                                input logic [3:0] st, input logic [9:0] eh,
                                input logic [9:0] ev, input logic [2:0] hits,
                                input logic idle, input logic [9:0] prh,
                                input logic [9:0] prv);
        vec_t v;
        v.rst = rst; v.tick = tick; v.fire = fire; v.cont = cont;
        v.pl_h = pl_h; v.pl_v = pl_v; v.reps = reps;
        v.st = st; v.eh = eh; v.ev = ev; v.hits = hits;
        v.idle = idle; v.prh = prh; v.prv = prv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        logic [3:0] st;
        st = {bus.game_win, bus.game_lose, bus.game_playing, bus.game_start};
        check({tag, " onehot"}, 32'($onehot(st)), 32'd1);
        check({tag, " state"}, 32'(st), 32'(v.st));
        check({tag, " enemy_h"}, 32'(bus.enemy_h), 32'(v.eh));
        check({tag, " enemy_v"}, 32'(bus.enemy_v), 32'(v.ev));
        check({tag, " hits"}, 32'({bus.enemy3_hit, bus.enemy2_hit, bus.enemy1_hit}),
              32'(v.hits));
        check({tag, " idle"}, 32'(bus.projectile_idle), 32'(v.idle));
        check({tag, " proj_h"}, 32'(bus.projectile_h), 32'(v.prh));
        check({tag, " proj_v"}, 32'(bus.projectile_v), 32'(v.prv));
    endtask

    task automatic apply(input vec_t v);
        for (int r = 0; r < v.reps; r++) begin
            reset            = v.rst;
            bus.frame_tick   = v.tick;
            bus.btn_fire     = v.fire;
            bus.btn_continue = v.cont;
            bus.player_h     = v.pl_h;
            bus.player_v     = v.pl_v;
            @(posedge clk);
            #1;
        end
        reset            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.btn_fire     = 1'b0;
        bus.btn_continue = 1'b0;
    endtask

    initial begin
        clk              = 1'b0;
        reset            = 1'b1;
        bus.frame_tick   = 1'b0;
        bus.btn_fire     = 1'b0;
        bus.btn_continue = 1'b0;
        bus.player_h     = 10'd300;
        bus.player_v     = 10'd400;

        //        rst tick fire cont  pl_h  pl_v reps  state    eh   ev  hits  idle prh  prv
        vecs.push_back(mk(0, 1, 1, 0, 300, 400,  1, S_START, 144,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 300, 400,  1, S_PLAY,  144,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0, 300, 400,  1, S_PLAY,  144,  35, 3'b000, 0, 332, 390));
        vecs.push_back(mk(0, 1, 0, 0, 300, 400,  3, S_PLAY,  150,  35, 3'b000, 0, 332, 372));
        vecs.push_back(mk(0, 0, 1, 0, 300, 400,  1, S_PLAY,  150,  35, 3'b000, 0, 332, 372));
        vecs.push_back(mk(0, 0, 0, 1, 300, 400,  1, S_PLAY,  150,  35, 3'b000, 0, 332, 372));
        vecs.push_back(mk(1, 1, 1, 1, 300, 400,  1, S_START, 144,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 402,  1, S_PLAY,  144,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 1, 0,   0, 402,  1, S_PLAY,  146,  35, 3'b000, 0,  32, 392));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402, 65, S_PLAY,  276,  35, 3'b000, 0,  32,   2));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402,  1, S_PLAY,  278,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402, 65, S_PLAY,  408,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402,  1, S_PLAY,  408,  55, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402,  1, S_PLAY,  406,  55, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402,  1, S_PLAY,  404,  55, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0, 528, 130,  1, S_PLAY,  404,  55, 3'b000, 0, 560, 120));
        vecs.push_back(mk(0, 1, 0, 0, 528, 402,  1, S_PLAY,  402,  55, 3'b010, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0, 528, 130,  1, S_PLAY,  402,  55, 3'b010, 0, 560, 120));
        vecs.push_back(mk(0, 1, 0, 0, 528, 402,  1, S_PLAY,  400,  55, 3'b010, 0, 560, 114));
        vecs.push_back(mk(0, 1, 0, 0, 528, 402, 19, S_PLAY,  362,  55, 3'b010, 0, 560,   0));
        vecs.push_back(mk(0, 1, 0, 0, 528, 402,  1, S_PLAY,  360,  55, 3'b010, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0, 368, 130,  1, S_PLAY,  360,  55, 3'b010, 0, 400, 120));
        vecs.push_back(mk(0, 1, 0, 0, 368, 402,  1, S_PLAY,  358,  55, 3'b011, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0, 668, 130,  1, S_PLAY,  358,  55, 3'b011, 0, 700, 120));
        vecs.push_back(mk(0, 1, 0, 0, 668, 100,  1, S_WIN,   356,  55, 3'b111, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0,   0, 402,  1, S_WIN,   356,  55, 3'b111, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 402,  1, S_WIN,   356,  55, 3'b111, 1,   0,   0));
        vecs.push_back(mk(0, 0, 0, 1,   0, 402,  1, S_PLAY,  144,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 111,  1, S_PLAY,  146,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 110,  1, S_LOSE,  148,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 0, 1, 0, 300, 400,  1, S_LOSE,  148,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 1, 0, 0, 300, 400,  1, S_LOSE,  148,  35, 3'b000, 1,   0,   0));
        vecs.push_back(mk(0, 0, 0, 1, 300, 400,  1, S_PLAY,  144,  35, 3'b000, 1,   0,   0));

        // Power-on reset held for two cycles, then the reset values.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("por", mk(0, 0, 0, 0, 0, 0, 0, S_START, 144, 35, 3'b000, 1, 0, 0));

        // Reset state must hold with no inputs active.
        @(posedge clk);
        #1;
        check("por_hold state",
              32'({bus.game_win, bus.game_lose, bus.game_playing, bus.game_start}),
              32'(S_START));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Central game sequencer feeding the Graphics block: owns the one-hot game state (start/playing/lose/win), the enemy formation position, the player projectile and the per-enemy hit flags.
- Advances all motion once per video frame on `frame_tick`, resolves projectile–enemy collisions and decides win/lose.
- Sits between the debounced button inputs / player movement logic and the renderer.

Parameters:
- H_MIN, 144, leftmost visible hCount; the formation never moves left of it.
- H_MAX, 783, rightmost visible hCount; the formation's right edge never passes it.
- V_MIN, 35, top visible vCount; enemy_v value on every game (re)start.
- ENEMY_STEP, 2, formation horizontal move per frame.
- ENEMY_DROP, 20, formation descent per edge bounce.
- PROJ_SPEED, 6, projectile upward move per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame (during vertical blank)
- btn_fire  in  1  one-cycle debounced pulse
- btn_continue  in  1  one-cycle debounced pulse
- player_h  in  10  player sprite left column (sprite is 75 wide)
- player_v  in  10  player sprite top row
- game_start, game_playing, game_lose, game_win  out  1 each  one-hot state flags
- enemy_h  out  10  formation left column; enemies at +0, +150, +300, each 75x75
- enemy_v  out  10  formation top row
- enemy1_hit, enemy2_hit, enemy3_hit  out  1 each  enemy destroyed
- projectile_h, projectile_v  out  10  projectile top-left; the projectile is 10x10
- projectile_idle  out  1  no projectile in flight

Behaviour:
- All outputs are registered. Reset is synchronous, active-high, and takes priority over every other input, including mid-game.
- Values on reset:
  - state = START.
  - enemy_h = H_MIN, enemy_v = V_MIN, direction = right.
  - All hit flags = 0.
  - projectile_idle = 1, projectile_h = projectile_v = 0.
- Exactly one state flag is high at all times.
- State transitions:
  - START, LOSE, WIN: on btn_continue, go to PLAYING and re-initialise the enemy, projectile and hit registers to their reset values in the same cycle.
  - In these three states, frame_tick and btn_fire are ignored and all object registers hold.
  - PLAYING: btn_continue is ignored.
- Fire (PLAYING only): if btn_fire and projectile_idle, then next cycle:
  - projectile_idle = 0
  - projectile_h = player_h + 32
  - projectile_v = player_v − 10
- Fire while a projectile is in flight is ignored.
- Fire coinciding with frame_tick: the launch wins, and the projectile does not move that frame.
- On frame_tick in PLAYING, all decisions use the current registered values and all updates land together one cycle later:
  1. Collision, only if the projectile is in flight. Enemy k (k = 0..2) is hit when it is not already hit and the rectangles overlap:
     - [ph, ph+10) overlaps [eh+150k, eh+150k+75), and
     - [pv, pv+10) overlaps [ev, ev+75).
     On a hit, set that enemyN_hit and set projectile_idle = 1. If more than one overlaps, only the lowest index is hit.
  2. Projectile motion, if in flight and not hit:
     - If pv < PROJ_SPEED, set projectile_idle = 1 (off the top).
     - Otherwise pv −= PROJ_SPEED.
  3. Formation motion:
     - Moving right: if eh + 375 + ENEMY_STEP > H_MAX + 1, reverse direction, ev += ENEMY_DROP, eh unchanged; else eh += ENEMY_STEP.
     - Moving left: if eh < H_MIN + ENEMY_STEP, reverse direction, ev += ENEMY_DROP, eh unchanged; else eh −= ENEMY_STEP.
  4. Outcome:
     - If all three hit flags are 1 after this tick's update, go to WIN.
     - Else if ev + 75 ≥ player_v (current ev), go to LOSE.
     - WIN takes priority over LOSE when both occur in the same tick.
- Arithmetic: all position sums and compares are evaluated in 11 bits so that eh+375 and similar sums cannot wrap. Stored positions are 10 bits.
- While idle, the projectile registers park at 0,0 (inside the blanking region).

Test Plan:
- Reset mid-PLAYING:
  - Stimulus: reset for 1 cycle.
  - Required response: next cycle shows game_start=1, enemy_h=144, enemy_v=35, all hit flags=0, projectile_idle=1, projectile_h=projectile_v=0.
- START → PLAYING, then fire:
  - Stimulus: btn_continue, then btn_fire with player=(300,400).
  - Required response: projectile at (332,390) with idle=0. After 3 frame_ticks, projectile_v=372. A second btn_fire while in flight leaves the position unchanged.
- Bounce:
  - Stimulus: formation moving right with enemy_h=408, then one frame_tick.
  - Required response: 408+375+2=785 > 784, so enemy_h stays 408, enemy_v increases by 20, direction becomes left. The following tick gives enemy_h=406.
- Hit:
  - Stimulus: enemy_h=200, enemy_v=100, projectile at (360,170), frame_tick.
  - Required response: enemy2 is hit (its span is [350,425) horizontally and [100,175) vertically), enemy2_hit=1, projectile_idle=1, enemy1_hit and enemy3_hit stay 0.
- Win and lose:
  - Win: with two enemies already hit, hitting the third yields game_win=1 on the same tick, even when ev+75 ≥ player_v on that tick.
  - Lose: with no hit and enemy_v=326, player_v=400, one frame_tick yields game_lose=1 (326+75=401 ≥ 400).
- Continue from WIN/LOSE:
  - Stimulus: btn_continue in WIN or LOSE.
  - Required response: game_playing=1, enemy_h=144, enemy_v=35, all hit flags=0, projectile_idle=1. btn_fire pulses applied in WIN/LOSE beforehand have no effect.
